h14tx_period_sched: RTL and testbench

- Registered period scheduler for the h14tx transmit path. Sits between h14tx_timings_top and the per-channel h14tx_encoding_top instances.
- From the raster position it drives `period` and the per-channel control bits. Video preamble and guard bands are placed ahead of every active line.
- Data islands of 1..MaxPackets packets are inserted into horizontal blanking whenever a packet source offers packets and the remaining blanking budget allows.

---
 rtl/h14tx_period_sched.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_h14tx_period_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/h14tx_period_sched.sv
// -----------------------------------------------------------------------------
// h14tx_period_sched
//
// Registered period scheduler for the h14tx transmit path. It sits between
// h14tx_timings_top and the per-channel h14tx_encoding_top instances.
//
// From the raster position it works out which period is on the wire. It also
// drives the per-channel control bits. Every line that is followed by an
// active line gets a video preamble and a leading guard band just before
// x wraps to 0. Data islands are placed in horizontal blanking. Each island
// carries 1..MaxPackets packets of 32 cycles. An island starts only when a
// packet source offers a packet and the rest of the blanking interval can
// hold a whole packet plus its guards and the minimum control gap.
//
// Every output is registered. The outputs seen in cycle t+1 describe the
// x/y/hsync/vsync presented in cycle t.
//
// Ports
//   clk         in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   x           in   horizontal position, 0..FrameWidth-1
//   y           in   vertical position, 0..FrameHeight-1
//   hsync       in   horizontal sync
//   vsync       in   vertical sync
//   pkt_valid   in   packet source has a 32-cycle packet ready
//   pkt_ready   out  one-cycle pulse, packet accepted, its first cycle is now
//   pkt_idx     out  cycle index inside the current packet, 0..31
//   period      out  current period (h14tx_sched_pkg::period_t)
//   ctl         out  control bits per channel, ctl[0] = {hsync, vsync}
//   island_pkts out  (only with H14TX_SCHED_STATS_EN) packets accepted in
//                    the previous frame, saturating at 255
//
// Optional build macro
//   H14TX_SCHED_STATS_EN  adds the island_pkts statistics output
// -----------------------------------------------------------------------------

package h14tx_sched_pkg;

  typedef enum logic [2:0] {
    Control,
    VideoPreamble,
    VideoGuard,
    VideoActive,
    DataIslandPreamble,
    DataIslandGuard,
    DataIslandActive
  } period_t;

  typedef logic [1:0] ctl_t;

endpackage

module h14tx_period_sched
  import h14tx_sched_pkg::*;
#(
  parameter int BitWidth     = 11,
  parameter int BitHeight    = 10,
  parameter int FrameWidth   = 1650,
  parameter int FrameHeight  = 750,
  parameter int ActiveWidth  = 1280,
  parameter int ActiveHeight = 720,
  parameter int PreambleLen  = 8,
  parameter int GuardLen     = 2,
  parameter int IslandOffset = 10,
  parameter int MinCtlLen    = 12,
  parameter int MaxPackets   = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  output logic [4:0]           pkt_idx,
  output period_t              period,
  output ctl_t [2:0]           ctl
`ifdef H14TX_SCHED_STATS_EN
  ,
  output logic [7:0]           island_pkts
`endif
);

  localparam int PktLen    = 32;
  localparam int Vps       = FrameWidth - PreambleLen - GuardLen;
  localparam int IslandX   = ActiveWidth + IslandOffset;
  localparam int StartCost = PreambleLen + GuardLen + PktLen + GuardLen + MinCtlLen;
  localparam int ContCost  = PktLen + GuardLen + MinCtlLen;
  localparam int IslandsOk =
    (ActiveWidth + IslandOffset + PreambleLen + 2 * GuardLen + PktLen + MinCtlLen <= Vps) ? 1 : 0;
  localparam int PhMax     = (PreambleLen > GuardLen) ? PreambleLen : GuardLen;
  localparam int PhW       = (PhMax > 1) ? $clog2(PhMax) : 1;
  localparam int CntW      = $clog2(MaxPackets + 1);

  // If the earliest island cannot fit before the video preamble of an active
  // line, the scheduler would never find a usable slot. Such a configuration
  // is flagged at elaboration, and start_ok below stays low so the FSM never
  // leaves IDLE.
  if (IslandsOk == 0) begin : g_cfg_check
    $error("h14tx_period_sched: data island window does not fit ahead of the video preamble");
  end

  typedef enum logic [2:0] {
    IDLE,
    DI_PRE,
    DI_LGUARD,
    DI_DATA,
    DI_TGUARD
  } state_t;

  typedef struct packed {
    period_t period;
    ctl_t    c2;
    ctl_t    c1;
  } ow_t;

  state_t          state;
  logic [PhW-1:0]  phase;
  logic [CntW-1:0] pkt_cnt;
  ow_t             ow_q;
  ctl_t            ctl0_q;

  int      x_i;
  int      y_i;
  logic    next_active;
  int      bound;
  logic    start_ok;
  logic    cont_ok;
  logic    vid_hit;
  period_t vid_p;
  logic    lg_done;
  logic    take_next;
  ow_t     ow_ctrl;
  ow_t     ow_pre;
  ow_t     ow_grd;
  ow_t     ow_act;

  // Channels 1 and 2 only carry non-zero control bits during preambles.
  // They say which kind of period follows.
  function automatic ow_t make_ow(input period_t p);
    ow_t o;
    o.period = p;
    o.c1     = (p == VideoPreamble || p == DataIslandPreamble) ? 2'b01 : 2'b00;
    o.c2     = (p == DataIslandPreamble) ? 2'b01 : 2'b00;
    return o;
  endfunction

  assign x_i = int'(x);
  assign y_i = int'(y);

  // Raster decode. The video periods depend only on x/y. They override
  // whatever the island FSM wants. The island budget is measured against
  // the video preamble when the next line is active, and against the end of
  // the line otherwise. The continuation check compares against the x of
  // the cycle that would carry the new packet's first word, which is the
  // cycle right after pkt_idx==31.
  always_comb begin
    next_active = (y_i + 1 < ActiveHeight) || (y_i == FrameHeight - 1);
    bound       = next_active ? Vps : FrameWidth;
    start_ok    = (IslandsOk != 0) && (x_i == IslandX) && pkt_valid &&
                  (x_i + StartCost <= bound);
    cont_ok     = pkt_valid && (int'(pkt_cnt) < MaxPackets) &&
                  (x_i + ContCost <= bound);

    vid_hit = 1'b0;
    vid_p   = Control;
    if (x_i < ActiveWidth && y_i < ActiveHeight) begin
      vid_hit = 1'b1;
      vid_p   = VideoActive;
    end else if (next_active && x_i >= Vps && x_i < Vps + PreambleLen) begin
      vid_hit = 1'b1;
      vid_p   = VideoPreamble;
    end else if (next_active && x_i >= FrameWidth - GuardLen && x_i < FrameWidth) begin
      vid_hit = 1'b1;
      vid_p   = VideoGuard;
    end

    ow_ctrl = make_ow(vid_hit ? vid_p : Control);
    ow_pre  = make_ow(vid_hit ? vid_p : DataIslandPreamble);
    ow_grd  = make_ow(vid_hit ? vid_p : DataIslandGuard);
    ow_act  = make_ow(vid_hit ? vid_p : DataIslandActive);

    lg_done   = (state == DI_LGUARD) && (phase == PhW'(GuardLen - 1));
    take_next = (state == DI_DATA) && (pkt_idx == 5'd31) && cont_ok;
  end

  // Island FSM with registered outputs. The state register describes the
  // raster position that was just sampled, so each transition also loads the
  // period for that same position. phase counts cycles inside the preamble
  // and guard states. pkt_cnt counts packets accepted in the current island,
  // so it can be held against MaxPackets. Outside DI_DATA, pkt_idx rests
  // at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      pkt_cnt   <= '0;
      pkt_idx   <= '0;
      pkt_ready <= 1'b0;
      ow_q      <= make_ow(Control);
      ctl0_q    <= 2'b00;
    end else begin
      pkt_ready <= 1'b0;
      ctl0_q    <= {hsync, vsync};
      ow_q      <= ow_ctrl;
      case (state)
        IDLE: begin
          phase   <= '0;
          pkt_idx <= '0;
          pkt_cnt <= '0;
          if (start_ok) begin
            state <= DI_PRE;
            ow_q  <= ow_pre;
          end
        end
        DI_PRE: begin
          if (phase == PhW'(PreambleLen - 1)) begin
            state <= DI_LGUARD;
            phase <= '0;
            ow_q  <= ow_grd;
          end else begin
            phase <= phase + 1'b1;
            ow_q  <= ow_pre;
          end
        end
        DI_LGUARD: begin
          if (lg_done) begin
            state     <= DI_DATA;
            phase     <= '0;
            pkt_idx   <= '0;
            pkt_ready <= 1'b1;
            pkt_cnt   <= CntW'(1);
            ow_q      <= ow_act;
          end else begin
            phase <= phase + 1'b1;
            ow_q  <= ow_grd;
          end
        end
        DI_DATA: begin
          if (pkt_idx == 5'd31) begin
            pkt_idx <= '0;
            if (take_next) begin
              pkt_ready <= 1'b1;
              pkt_cnt   <= pkt_cnt + 1'b1;
              ow_q      <= ow_act;
            end else begin
              state <= DI_TGUARD;
              phase <= '0;
              ow_q  <= ow_grd;
            end
          end else begin
            pkt_idx <= pkt_idx + 5'd1;
            ow_q    <= ow_act;
          end
        end
        DI_TGUARD: begin
          if (phase == PhW'(GuardLen - 1)) begin
            state   <= IDLE;
            phase   <= '0;
            pkt_cnt <= '0;
          end else begin
            phase <= phase + 1'b1;
            ow_q  <= ow_grd;
          end
        end
        default: begin
          state   <= IDLE;
          phase   <= '0;
          pkt_cnt <= '0;
          pkt_idx <= '0;
        end
      endcase
    end
  end

  assign period = ow_q.period;
  assign ctl    = {ow_q.c2, ow_q.c1, ctl0_q};

`ifdef H14TX_SCHED_STATS_EN
  logic [7:0] frame_pkts;

  // Counts the packets accepted during the frame that is running. At the
  // first pixel of a frame the total moves to island_pkts and the count
  // starts again. No island can be open at x==0, so no acceptance can be
  // lost at that moment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_pkts  <= '0;
      island_pkts <= '0;
    end else if (x_i == 0 && y_i == 0) begin
      island_pkts <= frame_pkts;
      frame_pkts  <= '0;
    end else if ((lg_done || take_next) && frame_pkts != 8'hFF) begin
      frame_pkts <= frame_pkts + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_h14tx_period_sched.sv
// -----------------------------------------------------------------------------
// tb_h14tx_period_sched
//
// Directed bench for h14tx_period_sched. Two instances share one stimulus:
// dut_a uses the default 720p parameters, dut_b limits islands to 3 packets.
// Each applied vector pushes the expected outputs of both instances into a
// scoreboard queue. The expected values come from a hand-derived layout of
// the line. A monitor on the falling edge pops each entry when it falls due
// and compares it with both instances.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_h14tx_period_sched;
  import h14tx_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        pkt_valid = 1'b0;

  logic        rdy_a, rdy_b;
  logic [4:0]  idx_a, idx_b;
  period_t     per_a, per_b;
  ctl_t [2:0]  ctl_a, ctl_b;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    int         due;
    int         xv;
    int         yv;
    period_t    per_a;
    logic [5:0] ctl_a;
    logic       rdy_a;
    logic [4:0] idx_a;
    period_t    per_b;
    logic [5:0] ctl_b;
    logic       rdy_b;
    logic [4:0] idx_b;
  } exp_t;

  exp_t sb[$];

  h14tx_period_sched dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .hsync     (hsync),
    .vsync     (vsync),
    .pkt_valid (pkt_valid),
    .pkt_ready (rdy_a),
    .pkt_idx   (idx_a),
    .period    (per_a),
    .ctl       (ctl_a)
  );

  h14tx_period_sched #(.MaxPackets(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .hsync     (hsync),
    .vsync     (vsync),
    .pkt_valid (pkt_valid),
    .pkt_ready (rdy_b),
    .pkt_idx   (idx_b),
    .period    (per_b),
    .ctl       (ctl_b)
  );

  always #5 clk = ~clk;

  // Counts rising edges, so scoreboard entries can be tagged with the edge
  // whose output they describe.
  always @(posedge clk) cyc <= cyc + 1;

  // Expected layout for 720p. An island with n packets has its preamble at
  // 1290..1297 and its leading guard at 1298..1299. The data runs from 1300
  // for 32*n cycles, and a 2-cycle trailing guard follows. Video periods win.
  function automatic void model(input int xv, input int yv, input int n,
                                output period_t p, output logic r, output logic [4:0] i);
    logic na;
    na = (yv + 1 < 720) || (yv == 749);
    p  = Control;
    r  = 1'b0;
    i  = 5'd0;
    if (xv < 1280 && yv < 720) p = VideoActive;
    else if (na && xv >= 1640 && xv <= 1647) p = VideoPreamble;
    else if (na && xv >= 1648) p = VideoGuard;
    else if (n > 0) begin
      if (xv >= 1290 && xv <= 1297) p = DataIslandPreamble;
      else if (xv >= 1298 && xv <= 1299) p = DataIslandGuard;
      else if (xv >= 1300 && xv < 1300 + 32 * n) begin
        p = DataIslandActive;
        i = 5'((xv - 1300) % 32);
        r = ((xv - 1300) % 32) == 0;
      end else if (xv >= 1300 + 32 * n && xv < 1302 + 32 * n) p = DataIslandGuard;
    end
  endfunction

  function automatic logic [5:0] ctl_of(input period_t p, input logic hs, input logic vs);
    logic [1:0] c1, c2;
    c1 = (p == VideoPreamble || p == DataIslandPreamble) ? 2'b01 : 2'b00;
    c2 = (p == DataIslandPreamble) ? 2'b01 : 2'b00;
    return {c2, c1, hs, vs};
  endfunction

  // Drives one raster position just after a rising edge. It queues the
  // outputs expected after the following edge. rexp marks vectors whose
  // outputs are expected to be held at reset values.
  task automatic applyStimulus(input int xv, input int yv, input logic hs, input logic vs,
                               input logic valid, input logic rn, input logic rexp,
                               input int na, input int nb);
    exp_t       e;
    period_t    p;
    logic       r;
    logic [4:0] i;
    @(posedge clk);
    #1;
    x         = 11'(xv);
    y         = 10'(yv);
    hsync     = hs;
    vsync     = vs;
    pkt_valid = valid;
    rst_n     = rn;
    e.due = cyc + 1;
    e.xv  = xv;
    e.yv  = yv;
    if (rexp) begin
      e.per_a = Control; e.ctl_a = '0; e.rdy_a = 1'b0; e.idx_a = '0;
      e.per_b = Control; e.ctl_b = '0; e.rdy_b = 1'b0; e.idx_b = '0;
    end else begin
      model(xv, yv, na, p, r, i);
      e.per_a = p; e.ctl_a = ctl_of(p, hs, vs); e.rdy_a = r; e.idx_a = i;
      model(xv, yv, nb, p, r, i);
      e.per_b = p; e.ctl_b = ctl_of(p, hs, vs); e.rdy_b = r; e.idx_b = i;
    end
    sb.push_back(e);
  endtask

  // vmode: 0 no packets, 1 valid only around the start x (one packet),
  // 2 valid held, 3 valid raised only after the start x.
  // tog drives hsync/vsync from x bits, so channel 0 changes every cycle.
  // rst_x >= 0 pulls rst_n low for rst_len vectors starting at that x. Once
  // reset has hit, no island is expected for the rest of the line.
  task automatic runLine(input int yv, input int vmode, input bit tog,
                         input int na, input int nb, input int rst_x, input int rst_len);
    for (int xv = 1276; xv < 1650; xv++) begin
      logic [10:0] xb;
      logic        v, hs, vs, rn, re;
      int          ma, mb;
      xb = 11'(xv);
      case (vmode)
        1:       v = (xv >= 1280 && xv <= 1300);
        2:       v = 1'b1;
        3:       v = (xv >= 1291);
        default: v = 1'b0;
      endcase
      if (tog) begin
        hs = xb[0];
        vs = xb[1];
      end else begin
        hs = (xv >= 1390 && xv < 1430);
        vs = (yv >= 725 && yv < 730);
      end
      rn = !(rst_x >= 0 && xv >= rst_x && xv < rst_x + rst_len);
      re = (rst_x >= 0 && xv >= rst_x - 1 && xv <= rst_x + rst_len - 1);
      ma = na;
      mb = nb;
      if (rst_x >= 0 && xv >= rst_x + rst_len) begin
        ma = 0;
        mb = 0;
      end
      applyStimulus(xv, yv, hs, vs, v, rn, re, ma, mb);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    n_vec++;
    if (per_a !== e.per_a || ctl_a !== e.ctl_a || rdy_a !== e.rdy_a || idx_a !== e.idx_a) begin
      n_miss++;
      $display("[TB] FAIL dut_a x=%0d y=%0d: got period=%s ctl=%h ready=%b idx=%0d, required period=%s ctl=%h ready=%b idx=%0d",
               e.xv, e.yv, per_a.name(), ctl_a, rdy_a, idx_a,
               e.per_a.name(), e.ctl_a, e.rdy_a, e.idx_a);
    end
    n_vec++;
    if (per_b !== e.per_b || ctl_b !== e.ctl_b || rdy_b !== e.rdy_b || idx_b !== e.idx_b) begin
      n_miss++;
      $display("[TB] FAIL dut_b x=%0d y=%0d: got period=%s ctl=%h ready=%b idx=%0d, required period=%s ctl=%h ready=%b idx=%0d",
               e.xv, e.yv, per_b.name(), ctl_b, rdy_b, idx_b,
               e.per_b.name(), e.ctl_b, e.rdy_b, e.idx_b);
    end
  endtask

  // Monitor. On each falling edge it compares the entry due for the last
  // rising edge. Entries that are overdue are reported and dropped.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      exp_t s;
      s = sb.pop_front();
      n_vec++;
      n_miss++;
      $display("[TB] FAIL stale x=%0d y=%0d: due at edge %0d, now edge %0d", s.xv, s.yv, s.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    $display("[TB] h14tx_period_sched directed run starting");

    // Held in reset with hsync/vsync high and an active-area position.
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);

    runLine(749, 0, 1'b0, 0, 0, -1, 0);
    runLine(719, 0, 1'b0, 0, 0, -1, 0);
    runLine(0,   0, 1'b0, 0, 0, -1, 0);
    runLine(10,  1, 1'b0, 1, 1, -1, 0);
    runLine(11,  2, 1'b0, 10, 3, -1, 0);
    runLine(12,  3, 1'b0, 0, 0, -1, 0);
    runLine(13,  2, 1'b0, 10, 3, 1348, 3);
    runLine(14,  2, 1'b0, 10, 3, -1, 0);
    runLine(15,  2, 1'b1, 10, 3, -1, 0);
    runLine(730, 2, 1'b0, 10, 3, -1, 0);
    runLine(719, 2, 1'b0, 10, 3, -1, 0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL drain: %0d expected outputs left uncompared, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
